// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake plus the uart write port and status outputs of
// the uart transmit arbiter, bundled so the arbiter can be wired in one go.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      uart_din;
    logic               uart_wr_en;
    logic               uart_tx_busy;
    logic [NREQ-1:0]    grant;
    logic               locked;
    logic               start_err;
    logic [15:0]        bytes_sent;

    // Environment side: requesters and the uart transmitter.
    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, uart_din, uart_wr_en, grant, locked, start_err, bytes_sent
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, uart_din, uart_wr_en, grant, locked, start_err, bytes_sent
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NREQ byte
// requesters. One byte is in flight at a time: grant, strobe wr_en, wait
// for tx_busy to rise and fall, then arbitrate again. A byte with
// req_last=0 locks the arbiter to its requester until that requester's
// req_last=1 byte is granted.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int DW            = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);
    // Timeout fires in the WAIT_START cycle where the counter would reach
    // START_TIMEOUT, i.e. START_TIMEOUT cycles after ISSUE.
    localparam logic [7:0]    TMO_LAST = 8'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            locked_q, locked_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [DW-1:0]   din_q, din_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [15:0]     bytes_q, bytes_d;

    logic [DW-1:0]   req_byte [NREQ];
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] eligible;
    logic [PW-1:0]   cand [NREQ];
    logic [NREQ-1:0] cand_hit;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;

    logic [NREQ-1:0] req_ready;
    logic            wr_en;
    logic            start_err;

    // While locked only the lock owner may win; everybody else is masked.
    assign eligible = locked_q ? (bus.req_valid & owner_mask) : bus.req_valid;

    // Per-requester slicing and the rotated scan order ptr+1, ptr+2, ...
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [PW:0] sum;

        assign req_byte[gi]   = bus.req_data[gi*DW +: DW];
        assign owner_mask[gi] = (owner_q == PW'(gi));
        assign sum            = {1'b0, ptr_q} + (PW+1)'(gi + 1);
        assign cand[gi]       = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                       : sum[PW-1:0];
        assign cand_hit[gi]   = eligible[cand[gi]];
        assign win_onehot[gi] = win_found && (win_idx == PW'(gi));
    end

    // Pick the first eligible requester in rotated order (lowest scan slot).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_found = 1'b1;
                win_idx   = cand[k];
            end
        end
    end

    // Next-state and output decode for the grant/issue/wait sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        locked_d  = locked_q;
        grant_d   = grant_q;
        din_d     = din_q;
        tmo_d     = tmo_q;
        bytes_d   = bytes_q;
        req_ready = '0;
        wr_en     = 1'b0;
        start_err = 1'b0;

        case (state_q)
            ARB: begin
                // A busy transmitter (someone else using it) blocks grants.
                if (!bus.uart_tx_busy && win_found) begin
                    req_ready = win_onehot;
                    din_d     = req_byte[win_idx];
                    grant_d   = win_onehot;
                    ptr_d     = win_idx;
                    if (bus.req_last[win_idx]) begin
                        locked_d = 1'b0;
                    end else begin
                        locked_d = 1'b1;
                        owner_d  = win_idx;
                    end
                    state_d = ISSUE;
                end else begin
                    grant_d = '0;
                end
            end
            ISSUE: begin
                wr_en   = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (bus.uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // Frame never started: drop the byte, keep lock state.
                    start_err = 1'b1;
                    grant_d   = '0;
                    state_d   = ARB;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    bytes_d = bytes_q + 16'd1;
                    grant_d = '0;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and datapath registers; reset abandons any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            ptr_q    <= PTR_RST;
            owner_q  <= '0;
            locked_q <= 1'b0;
            grant_q  <= '0;
            din_q    <= '0;
            tmo_q    <= '0;
            bytes_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            grant_q  <= grant_d;
            din_q    <= din_d;
            tmo_q    <= tmo_d;
            bytes_q  <= bytes_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.uart_din   = din_q;
    assign bus.uart_wr_en = wr_en;
    assign bus.grant      = grant_q;
    assign bus.locked     = locked_q;
    assign bus.start_err  = start_err;
    assign bus.bytes_sent = bytes_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: scenarios queue source bytes and
// expected issues; a monitor checks every uart write strobe against the
// expected queue. A small uart model raises/lowers tx_busy.
module tb_uart_tx_arbiter;
    localparam int NREQ          = 4;
    localparam int DW            = 8;
    localparam int START_TIMEOUT = 16;
    localparam int FRAME         = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    uart_tx_arbiter #(
        .NREQ          (NREQ),
        .DW            (DW),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [NREQ-1:0] grant;
        logic            locked;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW:0]   src_q [NREQ][$];   // {last, data}
    int            n_vec    = 0;
    int            n_err    = 0;
    int            cyc      = 0;
    int            drop_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [NREQ-1:0] g, input logic l);
        exp_t e;
        e.data   = d;
        e.grant  = g;
        e.locked = l;
        exp_q.push_back(e);
    endtask

    function automatic bit src_any();
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Requester model: pop a byte once it was accepted, present the next one.
    initial begin
        logic [NREQ-1:0] acc;
        logic [DW:0]     head;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0) begin
                    head                     = src_q[i][0];
                    bus.req_valid[i]         = 1'b1;
                    bus.req_last[i]          = head[DW];
                    bus.req_data[i*DW +: DW] = head[DW-1:0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Uart model: busy rises one cycle after wr_en and lasts FRAME cycles,
    // unless drop_cnt asks it to ignore a write.
    initial begin
        bus.uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.uart_wr_en) begin
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    @(posedge clk);
                    #1;
                    bus.uart_tx_busy = 1'b1;
                    repeat (FRAME) @(posedge clk);
                    #1;
                    bus.uart_tx_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: every write strobe pops one expected issue.
    initial begin
        logic [NREQ-1:0] prev_ready;
        exp_t            e;
        prev_ready = '0;
        forever begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                check("ready_only_in_arb", 32'(bus.grant), 32'd0);
            end
            if (bus.uart_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_issue: got din 0x%0h grant %b, expected no issue",
                             bus.uart_din, bus.grant);
                end else begin
                    e = exp_q.pop_front();
                    $display("issue @%0d din=0x%0h grant=%b locked=%b (exp 0x%0h %b %b)",
                             cyc, bus.uart_din, bus.grant, bus.locked, e.data, e.grant, e.locked);
                    check("issue_din", 32'(bus.uart_din), 32'(e.data));
                    check("issue_grant", 32'(bus.grant), 32'(e.grant));
                    check("issue_locked", 32'(bus.locked), 32'(e.locked));
                    check("accept_latency_ready", 32'(prev_ready), 32'(e.grant));
                end
            end
            prev_ready = bus.req_ready;
        end
    end

    task automatic check_reset_values();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_uart_din", 32'(bus.uart_din), 32'd0);
        check("rst_uart_wr_en", 32'(bus.uart_wr_en), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_start_err", 32'(bus.start_err), 32'd0);
        check("rst_bytes_sent", 32'(bus.bytes_sent), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_any() || bus.grant != '0 || bus.uart_tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_idle_timeout: got %0d pending issues, expected 0", name, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!bus.uart_tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_busy_timeout: got tx_busy 0, expected 1", name);
        end
    endtask

    initial begin
        int n;
        int t0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        // Single byte from requester 2.
        src_q[2].push_back({1'b1, 8'hA5});
        push_exp(8'hA5, 4'b0100, 1'b0);
        wait_busy("single");
        check("single_grant_held", 32'(bus.grant), 32'h4);
        wait_idle("single");
        check("single_bytes_sent", 32'(bus.bytes_sent), 32'd1);
        check("single_locked", 32'(bus.locked), 32'd0);
        check("single_grant_idle", 32'(bus.grant), 32'd0);

        // Round-robin from reset priority.
        do_reset();
        src_q[0].push_back({1'b1, 8'h10}); src_q[0].push_back({1'b1, 8'h10});
        src_q[1].push_back({1'b1, 8'h11}); src_q[1].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h12});
        src_q[3].push_back({1'b1, 8'h13});
        push_exp(8'h10, 4'b0001, 1'b0);
        push_exp(8'h11, 4'b0010, 1'b0);
        push_exp(8'h12, 4'b0100, 1'b0);
        push_exp(8'h13, 4'b1000, 1'b0);
        push_exp(8'h10, 4'b0001, 1'b0);
        push_exp(8'h11, 4'b0010, 1'b0);
        wait_idle("rr");
        check("rr_bytes_sent", 32'(bus.bytes_sent), 32'd6);

        // Packet lock: prime pointer to 0, then requester 1 sends 3 bytes.
        do_reset();
        src_q[0].push_back({1'b1, 8'h20});
        push_exp(8'h20, 4'b0001, 1'b0);
        wait_idle("prime");
        src_q[1].push_back({1'b0, 8'hB1});
        src_q[1].push_back({1'b0, 8'hB2});
        src_q[1].push_back({1'b1, 8'hB3});
        src_q[0].push_back({1'b1, 8'hC0});
        src_q[3].push_back({1'b1, 8'hC3});
        push_exp(8'hB1, 4'b0010, 1'b1);
        push_exp(8'hB2, 4'b0010, 1'b1);
        push_exp(8'hB3, 4'b0010, 1'b0);
        push_exp(8'hC3, 4'b1000, 1'b0);
        push_exp(8'hC0, 4'b0001, 1'b0);
        wait_idle("lock");
        check("lock_bytes_sent", 32'(bus.bytes_sent), 32'd6);
        check("lock_released", 32'(bus.locked), 32'd0);

        // Start timeout: first write is ignored by the uart model.
        drop_cnt = 1;
        src_q[1].push_back({1'b1, 8'h55});
        src_q[2].push_back({1'b1, 8'h66});
        push_exp(8'h55, 4'b0010, 1'b0);
        push_exp(8'h66, 4'b0100, 1'b0);
        n = 0;
        while (!bus.uart_wr_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.start_err && n < 100);
        check("tmo_start_err_seen", 32'(bus.start_err), 32'd1);
        check("tmo_delay", 32'(cyc - t0), 32'(START_TIMEOUT));
        check("tmo_bytes_unchanged", 32'(bus.bytes_sent), 32'd6);
        @(negedge clk);
        check("tmo_pulse_width", 32'(bus.start_err), 32'd0);
        wait_idle("tmo");
        check("tmo_bytes_after", 32'(bus.bytes_sent), 32'd7);

        // Reset during WAIT_DONE while locked.
        src_q[3].push_back({1'b0, 8'h77});
        src_q[3].push_back({1'b1, 8'h78});
        src_q[0].push_back({1'b1, 8'h80});
        src_q[1].push_back({1'b1, 8'h81});
        src_q[2].push_back({1'b1, 8'h82});
        push_exp(8'h77, 4'b1000, 1'b1);
        wait_busy("midrst");
        @(negedge clk);
        check("midrst_locked_before", 32'(bus.locked), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        push_exp(8'h80, 4'b0001, 1'b0);
        push_exp(8'h81, 4'b0010, 1'b0);
        push_exp(8'h82, 4'b0100, 1'b0);
        push_exp(8'h78, 4'b1000, 1'b0);
        wait_idle("midrst");
        check("midrst_bytes_sent", 32'(bus.bytes_sent), 32'd4);

        // Counter wrap from a preloaded 0xFFFF.
        @(negedge clk);
        force dut.bytes_q = 16'hFFFF;
        @(negedge clk);
        release dut.bytes_q;
        @(negedge clk);
        check("wrap_preload", 32'(bus.bytes_sent), 32'hFFFF);
        src_q[1].push_back({1'b1, 8'h99});
        push_exp(8'h99, 4'b0010, 1'b0);
        wait_idle("wrap");
        check("wrap_bytes_sent", 32'(bus.bytes_sent), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares the single `uart` transmitter among `NREQ` byte requesters. It sits between the requester interfaces and the `uart` write port (`din`/`wr_en`/`tx_busy`), accepts one byte at a time through a valid/ready handshake, and issues it to the transmitter. It then waits for the frame to finish before granting again. Multi-byte packets can be locked to one requester until its `req_last` byte.

## Interface
- `NREQ`, 4: number of requesters, legal 2..8.
- `DW`, 8: byte width; must match `uart.din`.
- `START_TIMEOUT`, 16: cycles allowed for `tx_busy` to rise after `wr_en`; legal 2..255.

One clock; reset is synchronous and active-high, named `clk` and `reset` as in the rest of the UART environment.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: requester i has a byte on its data slice.
- `req_data` in NREQ*DW: requester i's byte at bits [i*DW +: DW].
- `req_last` in NREQ: byte is the final byte of a packet. 0 requests lock.
- `req_ready` out NREQ: one-hot accept strobe; a byte transfers when `req_valid[i] & req_ready[i]`.
- `uart_din` out DW: byte to `uart.din`.
- `uart_wr_en` out 1: one-cycle write strobe to `uart.wr_en`.
- `uart_tx_busy` in 1: from `uart.tx_busy`.
- `grant` out NREQ: one-hot owner of the byte currently in flight; 0 when idle.
- `locked` out 1: packet lock held by the current `grant`/lock owner.
- `start_err` out 1: one-cycle pulse when `tx_busy` fails to rise within `START_TIMEOUT`.
- `bytes_sent` out 16: count of bytes whose frame completed; wraps 0xFFFF→0.

## Operation
- **States:** ARB, ISSUE, WAIT_START, WAIT_DONE. Reset enters ARB.
- **ARB**
  - Grants only if `uart_tx_busy==0` and some eligible `req_valid` is set.
  - Eligibility when `locked==1`: only the lock owner; all others are ignored.
  - Eligibility when `locked==0`: all requesters.
  - Winner: the first eligible valid requester scanning from `ptr+1` mod NREQ upward.
  - On a grant, `req_ready[w]` is driven combinationally high that cycle.
  - Registered on the grant edge: `uart_din`←byte, `grant`←onehot(w), `ptr`←w.
  - Lock update on the grant edge: `req_last[w]==0` sets lock with owner w; `req_last[w]==1` clears lock.
  - After a grant: → ISSUE. Otherwise stay in ARB with `grant`=0.
- **ISSUE:** `uart_wr_en`=1 for exactly this cycle, `uart_din` stable. Clears the timeout counter. → WAIT_START.
- **WAIT_START**
  - `uart_tx_busy==1`: → WAIT_DONE.
  - Otherwise the counter increments. On reaching `START_TIMEOUT`: pulse `start_err`, drop the byte (no `bytes_sent` increment), → ARB.
  - Lock state is unchanged by a timeout.
- **WAIT_DONE:** when `uart_tx_busy==0`, increment `bytes_sent` and → ARB.
- A locked owner that deasserts `req_valid` holds the lock indefinitely. There is no lock watchdog.
- `uart_din` holds its last value outside ISSUE; `uart_wr_en` is 0 outside ISSUE.

## Timing
- **Reset values:** `req_ready`=0, `uart_din`=0, `uart_wr_en`=0, `grant`=0, `locked`=0, `start_err`=0, `bytes_sent`=0. Also `ptr`=NREQ-1, so requester 0 has first priority, and the timeout counter is 0.
- **Reset mid-operation:** all of the above are restored the next edge regardless of state; the in-flight byte is abandoned. The `uart` has its own reset.
- **Accept latency:** byte accepted in cycle T (ARB) → `uart_wr_en` high in T+1.
- **Back-to-back bytes:** the earliest next accept is the cycle after the ARB entry that follows `tx_busy` falling. Minimum spacing is ARB + ISSUE + ≥1 WAIT_START + frame length + 1.
- **Simultaneous events**
  - Valid requests arriving during ISSUE/WAIT_* wait; the requester holds `req_valid` and data.
  - `req_ready` is never high outside ARB, and never high for more than one requester.
  - If `uart_tx_busy` is already 1 in ARB (external use), no grant is made.
- `start_err` is exactly 1 cycle wide, asserted in the cycle WAIT_START exits to ARB.

## Test plan
- **Single byte.** Reset, then `req_valid[2]`=1, data 0xA5, last=1.
  - `req_ready[2]` for 1 cycle, `uart_wr_en` next cycle with `uart_din`=0xA5, `grant`=0b0100 until `tx_busy` falls.
  - `bytes_sent`=1, `locked`=0.
- **Round-robin.** All four requesters valid continuously with last=1, data 0x10+i.
  - Accept order 0,1,2,3,0,1; `uart_din` sequence 0x10,0x11,0x12,0x13,0x10,0x11.
- **Packet lock.** Requester 1 sends 3 bytes (last=0,0,1) while 0 and 3 are valid.
  - The three bytes from 1 are issued consecutively with `locked`=1 through the second byte.
  - Requester 3 is next, then 0.
- **Start timeout.** START_TIMEOUT=16, `tx_busy` held 0 after `wr_en`.
  - `start_err` pulses 16 cycles after ISSUE, `bytes_sent` unchanged, arbiter returns to ARB and grants the next requester.
- **Reset mid-frame.** Assert `reset` during WAIT_DONE with `locked`=1.
  - Next cycle: all outputs at reset values, `locked`=0; the first grant after release goes to requester 0 when all are valid.
- **Counter wrap.** Preload via 65536 completed frames (or force).
  - `bytes_sent` goes 0xFFFF→0x0000.
